// File: rtl/oculink_link_seq.sv
// OCuLink link sequencer: debounces cable presence, drives PERST#, waits for
// the PCIe link, launches the configurator and retries failed attempts up to
// MAX_RETRIES before parking in FAIL. All outputs are registered.
module oculink_link_seq #(
    parameter int unsigned DEBOUNCE_CYCLES     = 1024,
    parameter int unsigned PERST_CYCLES        = 25000000,
    parameter int unsigned LINK_TIMEOUT_CYCLES = 50000000,
    parameter int unsigned CFG_TIMEOUT_CYCLES  = 10000000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       user_clk,
    input  logic       sys_rst_n_c,
    input  logic       cprsnt,
    input  logic       user_lnk_up,
    input  logic       finished_config,
    input  logic       failed_config,
    input  logic       restart,
    output logic       perst_n,
    output logic       start_config,
    output logic       seq_ready,
    output logic       seq_failed,
    output logic [3:0] retry_cnt,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        ST_ABSENT    = 3'd0,
        ST_PERST     = 3'd1,
        ST_WAIT_LINK = 3'd2,
        ST_CONFIG    = 3'd3,
        ST_READY     = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    // Timer/debounce values at which the current cycle is the last one allowed.
    localparam logic [31:0] DEB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] PERST_LAST = 32'(PERST_CYCLES - 1);
    localparam logic [31:0] LINK_LAST  = 32'(LINK_TIMEOUT_CYCLES - 1);
    localparam logic [31:0] CFG_LAST   = 32'(CFG_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  MAX_R      = 4'(MAX_RETRIES);

    logic        cprsnt_s1_q, cprsnt_s2_q;
    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] deb_q, deb_d;
    logic [3:0]  retry_q, retry_d;
    logic [4:0]  retry_inc;
    logic        fail_evt;
    logic        restart_evt;
    logic        perst_n_q, start_config_q, seq_ready_q, seq_failed_q;

    assign retry_inc = {1'b0, retry_q} + 5'd1;

    // Next-state decision with priority removal > restart > failure > progress.
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        deb_d       = '0;
        fail_evt    = 1'b0;
        restart_evt = 1'b0;
        if (state_q != ST_ABSENT && cprsnt_s2_q) begin
            state_d = ST_ABSENT;
            retry_d = '0;
        end else if (state_q != ST_ABSENT && restart) begin
            state_d     = ST_PERST;
            retry_d     = '0;
            restart_evt = 1'b1;
        end else begin
            unique case (state_q)
                ST_ABSENT: begin
                    if (!cprsnt_s2_q) begin
                        if (deb_q == DEB_LAST) state_d = ST_PERST;
                        else                   deb_d   = deb_q + 32'd1;
                    end
                end
                ST_PERST: begin
                    if (timer_q == PERST_LAST) state_d = ST_WAIT_LINK;
                end
                ST_WAIT_LINK: begin
                    if (timer_q == LINK_LAST) fail_evt = 1'b1;
                    else if (user_lnk_up)     state_d  = ST_CONFIG;
                end
                ST_CONFIG: begin
                    // A simultaneous finished/failed report counts as a failure.
                    if (failed_config || !user_lnk_up || timer_q == CFG_LAST) fail_evt = 1'b1;
                    else if (finished_config) state_d = ST_READY;
                end
                ST_READY: begin
                    if (!user_lnk_up) fail_evt = 1'b1;
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: state_d = ST_ABSENT;
            endcase
            if (fail_evt) begin
                if (retry_inc < {1'b0, MAX_R}) begin
                    retry_d = retry_inc[3:0];
                    state_d = ST_PERST;
                end else begin
                    retry_d = MAX_R;
                    state_d = ST_FAIL;
                end
            end
        end
        // A restart inside PERST re-enters the same state, so it clears the timer too.
        timer_d = (state_d != state_q || restart_evt) ? '0 : timer_q + 32'd1;
    end

    // State, counters, synchronizer and registered outputs derived from the next state.
    always_ff @(posedge user_clk or negedge sys_rst_n_c) begin
        if (!sys_rst_n_c) begin
            cprsnt_s1_q    <= 1'b1;
            cprsnt_s2_q    <= 1'b1;
            state_q        <= ST_ABSENT;
            timer_q        <= '0;
            deb_q          <= '0;
            retry_q        <= '0;
            perst_n_q      <= 1'b0;
            start_config_q <= 1'b0;
            seq_ready_q    <= 1'b0;
            seq_failed_q   <= 1'b0;
        end else begin
            cprsnt_s1_q    <= cprsnt;
            cprsnt_s2_q    <= cprsnt_s1_q;
            state_q        <= state_d;
            timer_q        <= timer_d;
            deb_q          <= deb_d;
            retry_q        <= retry_d;
            perst_n_q      <= (state_d == ST_WAIT_LINK) || (state_d == ST_CONFIG) ||
                              (state_d == ST_READY);
            start_config_q <= (state_d == ST_CONFIG) && (state_q != ST_CONFIG);
            seq_ready_q    <= (state_d == ST_READY);
            seq_failed_q   <= (state_d == ST_FAIL);
        end
    end

    assign perst_n      = perst_n_q;
    assign start_config = start_config_q;
    assign seq_ready    = seq_ready_q;
    assign seq_failed   = seq_failed_q;
    assign retry_cnt    = retry_q;
    assign seq_state    = state_q;

endmodule

// File: tb/tb_oculink_link_seq.sv
// Bench for oculink_link_seq: directed scenarios plus randomized endpoint
// behaviour, every cycle compared against a behavioural sequencing model.
module tb_oculink_link_seq;

    localparam int DEB = 4;
    localparam int PC  = 10;
    localparam int LTO = 50;
    localparam int CTO = 40;
    localparam int MR  = 2;

    localparam int S_ABSENT = 0, S_PERST = 1, S_WAIT = 2, S_CONFIG = 3, S_READY = 4, S_FAIL = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cprsnt_i = 1'b1;
    logic       lnk_i = 1'b0;
    logic       fin_i = 1'b0;
    logic       fcfg_i = 1'b0;
    logic       restart_i = 1'b0;
    logic       perst_n, start_config, seq_ready, seq_failed;
    logic [3:0] retry_cnt;
    logic [2:0] seq_state;

    oculink_link_seq #(
        .DEBOUNCE_CYCLES(DEB), .PERST_CYCLES(PC), .LINK_TIMEOUT_CYCLES(LTO),
        .CFG_TIMEOUT_CYCLES(CTO), .MAX_RETRIES(MR)
    ) dut (
        .user_clk(clk), .sys_rst_n_c(rst_n), .cprsnt(cprsnt_i), .user_lnk_up(lnk_i),
        .finished_config(fin_i), .failed_config(fcfg_i), .restart(restart_i),
        .perst_n(perst_n), .start_config(start_config), .seq_ready(seq_ready),
        .seq_failed(seq_failed), .retry_cnt(retry_cnt), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state, m_time, m_lowrun, m_retry;
    bit m_s1, m_s2, m_start;

    task automatic m_reset();
        m_state = S_ABSENT; m_time = 0; m_lowrun = 0; m_retry = 0;
        m_s1 = 1; m_s2 = 1; m_start = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic m_step();
        bit sync = m_s2;
        int nxt = m_state;
        bit failed = 0;
        bit reentered = 0;
        if (m_state != S_ABSENT && sync) begin
            nxt = S_ABSENT; m_retry = 0;
        end else if (m_state != S_ABSENT && restart_i) begin
            nxt = S_PERST; m_retry = 0; reentered = 1;
        end else begin
            case (m_state)
                S_ABSENT: begin
                    m_lowrun = sync ? 0 : m_lowrun + 1;
                    if (m_lowrun == DEB) nxt = S_PERST;
                end
                S_PERST:  if (m_time + 1 == PC) nxt = S_WAIT;
                S_WAIT:   if (m_time + 1 == LTO) failed = 1; else if (lnk_i) nxt = S_CONFIG;
                S_CONFIG: if (fcfg_i || !lnk_i || m_time + 1 == CTO) failed = 1;
                          else if (fin_i) nxt = S_READY;
                S_READY:  if (!lnk_i) failed = 1;
                default:  ;
            endcase
            if (failed) begin
                if (m_retry + 1 < MR) begin m_retry++; nxt = S_PERST; end
                else begin m_retry = MR; nxt = S_FAIL; end
            end
        end
        m_start = (nxt == S_CONFIG) && (m_state != S_CONFIG);
        m_time  = (nxt != m_state || reentered) ? 0 : m_time + 1;
        if (nxt != S_ABSENT) m_lowrun = 0;
        m_state = nxt;
        m_s2 = m_s1;
        m_s1 = cprsnt_i;
    endtask

    task automatic compare_outputs();
        chk("seq_state",    seq_state,    m_state);
        chk("perst_n",      perst_n,      (m_state == S_WAIT || m_state == S_CONFIG || m_state == S_READY));
        chk("start_config", start_config, m_start);
        chk("seq_ready",    seq_ready,    (m_state == S_READY));
        chk("seq_failed",   seq_failed,   (m_state == S_FAIL));
        chk("retry_cnt",    retry_cnt,    m_retry);
    endtask

    task automatic tick();
        m_step();
        @(negedge clk);
        compare_outputs();
    endtask

    // ---------------- endpoint stimulus ----------------
    int link_delay = 5, cfg_delay = 8, cfg_mode = 0;
    int link_cnt = 0, cfg_cnt = 0;
    bit rand_mode = 0;

    // Drive link/config inputs from the expected sequencer state.
    task automatic drive_endpoint();
        if (rand_mode && m_state == S_PERST) begin
            link_delay = ($urandom_range(0, 9) == 0) ? 100000 : int'($urandom_range(0, 20));
            cfg_delay  = $urandom_range(0, 15);
            case ($urandom_range(0, 9))
                6: cfg_mode = 1;
                7: cfg_mode = 2;
                8: cfg_mode = 3;
                default: cfg_mode = 0;
            endcase
        end
        if (m_state == S_WAIT || m_state == S_CONFIG || m_state == S_READY) link_cnt++;
        else link_cnt = 0;
        lnk_i = (link_cnt != 0) && (link_cnt >= link_delay);
        if (rand_mode && (m_state == S_CONFIG || m_state == S_READY) && $urandom_range(0, 39) == 0)
            lnk_i = 0;
        if (m_start) cfg_cnt = 0; else cfg_cnt++;
        fin_i  = (m_state == S_CONFIG) && (cfg_cnt == cfg_delay) && (cfg_mode == 0 || cfg_mode == 2);
        fcfg_i = (m_state == S_CONFIG) && (cfg_cnt == cfg_delay) && (cfg_mode == 1 || cfg_mode == 2);
    endtask

    initial begin
        int perst_lo, starts, entries, prev, rm_left;
        bit fin_was, ready_seen;

        // Reset state
        m_reset();
        @(negedge clk);
        @(negedge clk);
        compare_outputs();
        rst_n = 1'b1;

        // Happy path
        cprsnt_i = 0; link_delay = 5; cfg_delay = 8; cfg_mode = 0;
        perst_lo = 0; starts = 0;
        for (int c = 0; c < 300 && m_state != S_READY; c++) begin
            drive_endpoint();
            fin_was = fin_i;
            tick();
            if (seq_state == 3'(S_PERST) && perst_n == 1'b0) perst_lo++;
            if (start_config) starts++;
            if (fin_was) chk("ready_after_finished", seq_ready, 1);
        end
        chk("happy_perst_low_cycles", perst_lo, PC);
        chk("happy_start_pulses", starts, 1);
        chk("happy_ready", seq_ready, 1);
        chk("happy_retry", retry_cnt, 0);
        for (int c = 0; c < 5; c++) begin drive_endpoint(); tick(); end

        // Cable removal in READY
        cprsnt_i = 1;
        for (int c = 0; c < 2; c++) begin drive_endpoint(); tick(); end
        chk("removal_still_ready", seq_state, S_READY);
        drive_endpoint(); tick();
        chk("removal_absent", seq_state, S_ABSENT);
        chk("removal_perst", perst_n, 0);
        chk("removal_ready", seq_ready, 0);
        chk("removal_retry", retry_cnt, 0);

        // Glitchy presence never debounces
        for (int c = 0; c < 30; c++) begin
            cprsnt_i = (c % 3 == 2);
            drive_endpoint(); tick();
        end
        chk("glitch_absent", seq_state, S_ABSENT);

        // Link timeout on every attempt
        cprsnt_i = 0; link_delay = 100000;
        entries = 0; prev = int'(seq_state);
        for (int c = 0; c < 400 && m_state != S_FAIL; c++) begin
            drive_endpoint(); tick();
            if (seq_state == 3'(S_PERST) && prev != S_PERST) entries++;
            prev = int'(seq_state);
        end
        chk("timeout_perst_attempts", entries, 2);
        chk("timeout_state", seq_state, S_FAIL);
        chk("timeout_failed", seq_failed, 1);
        chk("timeout_retry", retry_cnt, 2);
        chk("timeout_perst", perst_n, 0);

        // Restart from FAIL
        restart_i = 1; drive_endpoint(); tick(); restart_i = 0;
        chk("restart_state", seq_state, S_PERST);
        chk("restart_retry", retry_cnt, 0);
        chk("restart_failed", seq_failed, 0);

        // Simultaneous finished/failed config
        link_delay = 3; cfg_delay = 4; cfg_mode = 2; ready_seen = 0;
        for (int c = 0; c < 200 && m_retry != 1; c++) begin
            drive_endpoint(); tick();
            if (seq_ready) ready_seen = 1;
        end
        chk("both_cfg_state", seq_state, S_PERST);
        chk("both_cfg_retry", retry_cnt, 1);
        chk("both_cfg_ready_seen", ready_seen, 0);

        // Asynchronous reset mid-CONFIG
        cfg_mode = 3;
        for (int c = 0; c < 200 && m_state != S_CONFIG; c++) begin drive_endpoint(); tick(); end
        for (int c = 0; c < 3; c++) begin drive_endpoint(); tick(); end
        chk("pre_reset_in_config", seq_state, S_CONFIG);
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", seq_state, 0);
        chk("async_perst", perst_n, 0);
        chk("async_start", start_config, 0);
        chk("async_ready", seq_ready, 0);
        chk("async_failed", seq_failed, 0);
        chk("async_retry", retry_cnt, 0);
        m_reset();
        link_cnt = 0;
        @(negedge clk);
        compare_outputs();
        rst_n = 1'b1;

        // Randomized operation
        rand_mode = 1; rm_left = 0; cprsnt_i = 0;
        for (int c = 0; c < 3000; c++) begin
            drive_endpoint();
            restart_i = ($urandom_range(0, 299) == 0);
            if (rm_left > 0) begin
                cprsnt_i = 1; rm_left--;
            end else begin
                cprsnt_i = 0;
                if ($urandom_range(0, 599) == 0) rm_left = $urandom_range(1, 5);
            end
            tick();
        end
        restart_i = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/oculink_link_seq.md
OCULINK_LINK_SEQ -- requirements
Module: oculink_link_seq

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1024: consecutive synchronized cprsnt-low cycles required to declare a device present.
REQ-002 SHALL have parameter PERST_CYCLES, default 25000000: perst_n low time, in user_clk cycles, per reset attempt.
REQ-003 SHALL have parameter LINK_TIMEOUT_CYCLES, default 50000000: maximum wait for user_lnk_up after perst_n release.
REQ-004 SHALL have parameter CFG_TIMEOUT_CYCLES, default 10000000: maximum wait for configurator completion.
REQ-005 SHALL have parameter MAX_RETRIES, default 3, range 1..15: failed attempts tolerated before the FAIL state.
REQ-006 SHALL have port user_clk, input, 1: single clock for all logic.
REQ-007 SHALL have port sys_rst_n_c, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port cprsnt, input, 1: asynchronous cable-present pin; 0 means present.
REQ-009 SHALL have port user_lnk_up, input, 1: PCIe link up from the core.
REQ-010 SHALL have ports finished_config and failed_config, input, 1 each: configurator completion status.
REQ-011 SHALL have port restart, input, 1: single-cycle request to retrain.
REQ-012 SHALL have port perst_n, output, 1: PERST# to the endpoint.
REQ-013 SHALL have port start_config, output, 1: single-cycle configurator start pulse.
REQ-014 SHALL have ports seq_ready and seq_failed, output, 1 each: link configured / sequencing abandoned.
REQ-015 SHALL have port retry_cnt, output, 4: failed attempts since the last clean start.
REQ-016 SHALL have port seq_state, output, 3: encoded state for the VIO debug probe.

Function
REQ-017 SHALL pass cprsnt through a 2-flop synchronizer before any use.
REQ-018 SHALL implement states, with seq_state encodings:
- ABSENT = 0
- PERST = 1
- WAIT_LINK = 2
- CONFIG = 3
- READY = 4
- FAIL = 5
REQ-019 SHALL register all outputs so they change on the same edge as the state register.
REQ-020 SHALL keep a 32-bit state timer that is cleared on every state transition and increments by 1 per cycle otherwise.
REQ-021 ABSENT: perst_n=0; go to PERST after DEBOUNCE_CYCLES consecutive synchronized-low cprsnt samples; any high sample restarts the debounce count.
REQ-022 PERST: perst_n=0; go to WAIT_LINK after exactly PERST_CYCLES cycles in this state.
REQ-023 WAIT_LINK: perst_n=1.
- user_lnk_up=1 goes to CONFIG.
- Timer reaching LINK_TIMEOUT_CYCLES is a failed attempt.
REQ-024 CONFIG: start_config=1 on the first cycle in the state only.
- finished_config goes to READY.
- failed_config, user_lnk_up=0, or timer reaching CFG_TIMEOUT_CYCLES is a failed attempt.
- If finished_config and failed_config are both high in one cycle, the attempt counts as failed.
REQ-025 READY: seq_ready=1, perst_n=1; user_lnk_up=0 is a failed attempt.
REQ-026 On a failed attempt, the sequencer SHALL act on retry_cnt as follows:
- If retry_cnt+1 < MAX_RETRIES: increment retry_cnt and go to PERST.
- Otherwise: set retry_cnt to MAX_RETRIES and go to FAIL.
REQ-027 FAIL: perst_n=0, seq_failed=1; the state holds until restart or removal.
REQ-028 restart=1 in any state except ABSENT SHALL clear retry_cnt and go to PERST next cycle, even in mid-PERST (the timer restarts).
REQ-029 Synchronized cprsnt=1 in any state except ABSENT SHALL go to ABSENT next cycle, clear retry_cnt, and drive perst_n=0.
REQ-030 Event priority in one cycle SHALL be: removal > restart > failure/timeout > progress.
REQ-031 seq_ready SHALL be 1 only in READY, seq_failed only in FAIL, and perst_n=1 only in WAIT_LINK, CONFIG and READY.

Reset
REQ-032 When sys_rst_n_c=0, the block SHALL immediately (asynchronously) drive:
- state ABSENT, timer 0, debounce count 0, synchronizer flops 1
- perst_n=0, start_config=0, seq_ready=0, seq_failed=0, retry_cnt=0, seq_state=0
REQ-033 Reset deassertion mid-operation SHALL restart sequencing from ABSENT with no pulse on start_config.

Verification (DEBOUNCE=4, PERST=10, LINK_TO=50, CFG_TO=40, MAX_RETRIES=2)
REQ-034 Happy path:
- Stimulus: cprsnt held 0; user_lnk_up rises 5 cycles after perst_n rises; finished_config pulses 8 cycles after start_config.
- Response: perst_n low for exactly 10 cycles in PERST; one start_config pulse; seq_ready=1 the cycle after finished_config; retry_cnt=0.
REQ-035 Link timeout:
- Stimulus: user_lnk_up never rises.
- Response: two PERST attempts; FAIL entered after the second 50-cycle timeout; seq_failed=1, retry_cnt=2, perst_n=0.
REQ-036 Simultaneous config status:
- Stimulus: finished_config and failed_config high in the same cycle.
- Response: retry_cnt=1, state PERST, seq_ready stays 0.
REQ-037 Cable removal in READY:
- Stimulus: cprsnt driven 1 while in READY.
- Response: ABSENT 3 cycles later (2 synchronizer + 1); perst_n=0, seq_ready=0, retry_cnt=0.
REQ-038 Restart from FAIL:
- Stimulus: restart pulsed in FAIL.
- Response: PERST next cycle, retry_cnt=0, seq_failed=0.
- Also: cprsnt glitching high every 3rd cycle never leaves ABSENT.
REQ-039 Async reset:
- Stimulus: sys_rst_n_c asserted mid-CONFIG.
- Response: all outputs at reset values without waiting for a user_clk edge.
